float_to_int_arbiter: RTL

- Shares one float_to_int conversion unit among NUM_REQ requesters, e.g. rasteriser setup, texture address generation and the host command path.
- Sequences the unit's exec_strobe/done_strobe handshake for them.
- Round-robin fair grant; one conversion in flight at a time.
- Sits between the requesters and the float_to_int instance; drives that instance's inputs and consumes its outputs.

---
 rtl/float_to_int_arbiter_if.sv | 21 ++
 rtl/float_to_int_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/float_to_int_arbiter_if.sv
// Requester-side bus of float_to_int_arbiter: per-requester request lanes and the shared response lane.
interface float_to_int_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [32*NUM_REQ-1:0] req_value_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    resp_valid_o;
    logic [31:0]           resp_value_o;
    logic                  resp_error_o;

    modport master (
        output req_valid_i, req_value_i,
        input  req_ready_o, resp_valid_o, resp_value_o, resp_error_o
    );

    modport slave (
        input  req_valid_i, req_value_i,
        output req_ready_o, resp_valid_o, resp_value_o, resp_error_o
    );
endinterface

// File: rtl/float_to_int_arbiter.sv
// Round-robin arbiter sharing one float_to_int unit among NUM_REQ requesters, one conversion in flight.
// Optional watchdog on the WAIT state is enabled by defining FTI_ARB_TIMEOUT_EN.
module float_to_int_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_i,
    float_to_int_arbiter_if.slave bus,
    output logic [31:0]           fti_a_value_o,
    output logic                  fti_exec_strobe_o,
    input  logic [31:0]           fti_z_value_i,
    input  logic                  fti_done_strobe_i
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("float_to_int_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [31:0]        a_value_q, a_value_d;
    logic [31:0]        resp_value_q, resp_value_d;
    logic [31:0]        req_word [NUM_REQ];
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;

`ifdef FTI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             resp_error_q, resp_error_d;
    logic             timeout_hit;

    // The counter reads 0 on the first WAIT cycle, so TIMEOUT_CYCLES-1 marks the last one.
    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin : p_watchdog
        wait_cnt_d   = wait_cnt_q;
        resp_error_d = resp_error_q;
        if (state_q == ST_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (fti_done_strobe_i) begin
                resp_error_d = 1'b0;
            end else if (timeout_hit) begin
                resp_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            wait_cnt_q   <= '0;
            resp_error_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign bus.resp_error_o = resp_error_q && (state_q == ST_RESP);
`else
    assign bus.resp_error_o = 1'b0;
`endif

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_word[k] = bus.req_value_i[32*k +: 32];
    end

    // Search starts one past the last winner, so the previous winner has lowest priority.
    always_comb begin : p_rr_search
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_found && bus.req_valid_i[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin : p_handshake
        req_ready  = '0;
        resp_valid = '0;
        // State is already IDLE while reset is held, so ready is gated by reset as well.
        if (state_q == ST_IDLE && grant_found && reset_i) req_ready[grant_idx] = 1'b1;
        if (state_q == ST_RESP) resp_valid[gnt_q] = 1'b1;
    end

    always_comb begin : p_next
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        gnt_d             = gnt_q;
        a_value_d         = a_value_q;
        resp_value_d      = resp_value_q;
        fti_exec_strobe_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    a_value_d = req_word[grant_idx];
                    gnt_d     = grant_idx;
                    rr_ptr_d  = grant_idx;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fti_exec_strobe_o = 1'b1;
                state_d           = ST_WAIT;
            end
            ST_WAIT: begin
                if (fti_done_strobe_i) begin
                    resp_value_d = fti_z_value_i;
                    state_d      = ST_RESP;
                end
`ifdef FTI_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    resp_value_d = '0;
                    state_d      = ST_RESP;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            a_value_q    <= '0;
            resp_value_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            a_value_q    <= a_value_d;
            resp_value_q <= resp_value_d;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_value_o = resp_value_q;
    assign fti_a_value_o    = a_value_q;
endmodule
